// File: rtl/i2s_audio_transmitter_pkg.sv
// Shared definitions for the I2S audio transmitter.
// Holds the default frame geometry, the bit-counter width helpers and the
// stereo sample pair type used by producers on the sound bus.
package i2s_tx_pkg;

  localparam int W_SAMPLE   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef struct packed {
    logic signed [W_SAMPLE-1:0] left;
    logic signed [W_SAMPLE-1:0] right;
  } stereo_sample_t;

  // SCK cycles in one stereo frame for a given slot length.
  function automatic int frame_bits_of(input int slot_bits);
    return 2 * slot_bits;
  endfunction

  // Bit-counter width needed to index every SCK of a frame.
  function automatic int bit_cnt_w_of(input int slot_bits);
    return $clog2(2 * slot_bits);
  endfunction

endpackage

// File: rtl/i2s_audio_transmitter_if.sv
// Sample handshake bus between lab_top (producer) and the I2S transmitter.
//   sample_valid  producer offers a stereo pair
//   sample_left   left PCM, two's complement
//   sample_right  right PCM, two's complement
//   sample_ready  transmitter buffer can take the pair
// A pair transfers on a clk edge where valid and ready are both high.
interface i2s_audio_transmitter_if #(
  parameter int w_sample = 16
) ();

  logic                       sample_valid;
  logic signed [w_sample-1:0] sample_left;
  logic signed [w_sample-1:0] sample_right;
  logic                       sample_ready;

  modport master (
    output sample_valid,
    output sample_left,
    output sample_right,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_left,
    input  sample_right,
    output sample_ready
  );

endinterface

// File: rtl/i2s_audio_transmitter_sck_gen.sv
// Serial bit-clock divider for the I2S transmitter.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   enable    run the divider; 0 parks SCK low and clears the count
//   i2s_sck   serial bit clock, toggles every sck_half_clks clk
//   rise_evt  high in the clk whose edge takes SCK 0->1
//   fall_evt  high in the clk whose edge takes SCK 1->0
// The strobes are combinational so the consumer can register SD/WS on the
// very edge that drops SCK.
module i2s_sck_gen #(
  parameter int sck_half_clks = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic i2s_sck,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int DIV_W = $clog2(sck_half_clks);

  logic [DIV_W-1:0] div_cnt;
  logic             term;

  assign term     = enable && (div_cnt == DIV_W'(sck_half_clks - 1));
  assign rise_evt = term && !i2s_sck;
  assign fall_evt = term &&  i2s_sck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      i2s_sck <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      i2s_sck <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      i2s_sck <= ~i2s_sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_audio_transmitter.sv
// I2S master transmitter: accepts stereo PCM pairs over a valid/ready bus,
// buffers one pair and serialises it to an external I2S DAC/amplifier.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   enable       run the serial clock; 0 = idle, frame aborted
//   snd          sample handshake bus (slave side)
//   i2s_sck      serial bit clock
//   i2s_ws       word select, 0 = left, 1 = right (leads MSB by one SCK)
//   i2s_sd       serial data, MSB first, changes on SCK fall
//   frame_start  1-clk pulse when a frame is loaded into the shifter
//   underrun     1-clk pulse when that frame found the buffer empty
module i2s_audio_transmitter
  import i2s_tx_pkg::*;
#(
  parameter int clk_mhz       = 25,
  parameter int sck_half_clks = 4,
  parameter int w_sample      = W_SAMPLE,
  parameter int slot_bits     = SLOT_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  i2s_audio_transmitter_if.slave        snd,
  output logic                          i2s_sck,
  output logic                          i2s_ws,
  output logic                          i2s_sd,
  output logic                          frame_start,
  output logic                          underrun
);

  localparam int FB    = frame_bits_of(slot_bits);
  localparam int CNT_W = bit_cnt_w_of(slot_bits);

  if (sck_half_clks < 2 || w_sample > slot_bits || clk_mhz < 1) begin : g_param_check
    $error("i2s_audio_transmitter: illegal parameter combination");
  end

  // Full-frame image: left MSB-aligned in slot 0, right MSB-aligned in
  // slot 1, zero padding elsewhere. Shifting it out MSB first gives the
  // slot map directly.
  function automatic logic [FB-1:0] build_frame(input logic [w_sample-1:0] l,
                                                 input logic [w_sample-1:0] r);
    logic [FB-1:0] w;
    w = '0;
    w[FB-1 -: w_sample]        = l;
    w[slot_bits-1 -: w_sample] = r;
    return w;
  endfunction

  // WS rises one SCK before the right MSB and falls one SCK before the
  // next left MSB.
  function automatic logic ws_for(input logic [CNT_W-1:0] b);
    return (int'(b) >= slot_bits - 1) && (int'(b) <= FB - 2);
  endfunction

  logic                rise_evt;
  logic                fall_evt;
  logic                buf_full;
  logic [w_sample-1:0] buf_l;
  logic [w_sample-1:0] buf_r;
  logic [w_sample-1:0] last_l;
  logic [w_sample-1:0] last_r;
  logic [FB-1:0]       shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    next_bit;
  logic                accept;
  logic                frame_load;
  logic [FB-1:0]       frame_word;

  i2s_sck_gen #(
    .sck_half_clks (sck_half_clks)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .i2s_sck  (i2s_sck),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  assign snd.sample_ready = !buf_full;
  assign accept           = snd.sample_valid && !buf_full;
  assign next_bit         = (bit_cnt == CNT_W'(FB - 1)) ? '0 : bit_cnt + 1'b1;
  assign frame_load       = fall_evt && (next_bit == '0);
  // An empty buffer replays the previous pair rather than emitting silence.
  assign frame_word       = buf_full ? build_frame(buf_l, buf_r)
                                     : build_frame(last_l, last_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full    <= 1'b0;
      buf_l       <= '0;
      buf_r       <= '0;
      last_l      <= '0;
      last_r      <= '0;
      shreg       <= '0;
      bit_cnt     <= CNT_W'(FB - 1);
      i2s_ws      <= 1'b0;
      i2s_sd      <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      // A pair arriving on the same edge as an empty-buffer load lands in
      // the buffer and waits for the following frame.
      if (accept) begin
        buf_l    <= snd.sample_left;
        buf_r    <= snd.sample_right;
        buf_full <= 1'b1;
      end else if (frame_load && buf_full) begin
        buf_full <= 1'b0;
      end

      if (!enable) begin
        bit_cnt <= CNT_W'(FB - 1);
        i2s_ws  <= 1'b0;
        i2s_sd  <= 1'b0;
      end else if (fall_evt) begin
        bit_cnt <= next_bit;
        i2s_ws  <= ws_for(next_bit);
        if (frame_load) begin
          shreg       <= frame_word;
          i2s_sd      <= frame_word[FB-1];
          frame_start <= 1'b1;
          underrun    <= !buf_full;
          if (buf_full) begin
            last_l <= buf_l;
            last_r <= buf_r;
          end
        end else begin
          shreg  <= shreg << 1;
          i2s_sd <= shreg[FB-2];
        end
      end
    end
  end

  a_idle_no_events: assert property (@(posedge clk) disable iff (!rst)
    !enable |-> !(rise_evt || fall_evt));

endmodule

// File: tb/tb_i2s_audio_transmitter.sv
module tb_i2s_audio_transmitter;
  import i2s_tx_pkg::*;

  localparam int HALF   = 4;
  localparam int W      = 16;
  localparam int SLOT   = 32;
  localparam int FB     = 64;
  localparam int PERIOD = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic sck, ws, sd, fs, ur;

  i2s_audio_transmitter_if #(.w_sample(W)) snd ();

  i2s_audio_transmitter #(
    .clk_mhz       (25),
    .sck_half_clks (HALF),
    .w_sample      (W),
    .slot_bits     (SLOT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .snd         (snd),
    .i2s_sck     (sck),
    .i2s_ws      (ws),
    .i2s_sd      (sd),
    .frame_start (fs),
    .underrun    (ur)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_fs = 0;
  logic [63:0] exp_ws;

  typedef struct {
    bit             offer;
    stereo_sample_t smp;
    logic [15:0]    exp_l;
    logic [15:0]    exp_r;
    bit             exp_ur;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string tag, output int waited, output logic u, output logic rdy);
    waited = 0;
    u = 1'b0;
    rdy = 1'b0;
    forever begin
      tick();
      waited++;
      if (fs) break;
      if (waited > 2 * PERIOD) begin
        check({tag, " frame_start timeout"}, 64'd0, 64'd1);
        return;
      end
    end
    u = ur;
    rdy = snd.sample_ready;
  endtask

  task automatic capture(output logic [63:0] sdw, output logic [63:0] wsw);
    int k, guard;
    logic prev;
    sdw = '0;
    wsw = '0;
    k = 0;
    guard = 0;
    prev = sck;
    while (k < FB) begin
      tick();
      guard++;
      if (guard > FB * 2 * HALF + 16) begin
        check("capture timeout", 64'd0, 64'd1);
        return;
      end
      if (!prev && sck) begin
        sdw[63-k] = sd;
        wsw[63-k] = ws;
        k++;
      end
      prev = sck;
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] sdw, input logic [63:0] wsw,
                             input logic [15:0] el, input logic [15:0] er);
    check({tag, " left"}, 64'(sdw[63:48]), 64'(el));
    check({tag, " right"}, 64'(sdw[31:16]), 64'(er));
    check({tag, " pad"}, 64'({sdw[47:32], sdw[15:0]}), 64'd0);
    check({tag, " ws"}, wsw, exp_ws);
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    logic rdy;
    int guard;
    snd.sample_left  = l;
    snd.sample_right = r;
    snd.sample_valid = 1'b1;
    guard = 0;
    do begin
      rdy = snd.sample_ready;
      tick();
      guard++;
      if (guard > 2 * PERIOD) begin
        check("offer timeout", 64'd0, 64'd1);
        rdy = 1'b1;
      end
    end while (!rdy);
    snd.sample_valid = 1'b0;
  endtask

  task automatic count_falls(input int n);
    int c, guard;
    logic prev;
    c = 0;
    guard = 0;
    prev = sck;
    while (c < n) begin
      tick();
      guard++;
      if (guard > 2 * PERIOD) begin
        check("fall count timeout", 64'd0, 64'd1);
        return;
      end
      if (prev && !sck) c++;
      prev = sck;
    end
  endtask

  initial begin
    int w;
    logic u, r;
    logic [63:0] sdw, wsw;
    logic moved;

    for (int k = 0; k < FB; k++) exp_ws[63-k] = (k >= SLOT - 1) && (k <= FB - 2);

    vt[0] = '{1'b1, '{16'hA5C3, 16'h1234}, 16'hA5C3, 16'h1234, 1'b0};
    vt[1] = '{1'b0, '{16'h0000, 16'h0000}, 16'hA5C3, 16'h1234, 1'b1};
    vt[2] = '{1'b1, '{16'h8000, 16'h7FFF}, 16'h8000, 16'h7FFF, 1'b0};
    vt[3] = '{1'b1, '{16'hFFFF, 16'h0001}, 16'hFFFF, 16'h0001, 1'b0};
    vt[4] = '{1'b1, '{16'h0000, 16'hFFFF}, 16'h0000, 16'hFFFF, 1'b0};
    vt[5] = '{1'b0, '{16'h0000, 16'h0000}, 16'h0000, 16'hFFFF, 1'b1};

    snd.sample_valid = 1'b0;
    snd.sample_left  = '0;
    snd.sample_right = '0;
    rst = 1'b0;
    enable = 1'b1;

    repeat (3) tick();
    check("reset outputs", 64'({sck, ws, sd, fs, ur}), 64'd0);
    check("reset ready", 64'(snd.sample_ready), 64'd1);

    @(negedge clk);
    rst = 1'b1;
    wait_fs("power-up", w, u, r);
    check("first fs latency", 64'(w), 64'd8);
    check("first fs underrun", 64'(u), 64'd1);
    prev_fs = cyc;
    capture(sdw, wsw);
    check_frame("idle frame", sdw, wsw, 16'h0000, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].offer) begin
        offer(vt[i].smp.left, vt[i].smp.right);
        check($sformatf("vec%0d ready drop", i), 64'(snd.sample_ready), 64'd0);
      end
      wait_fs($sformatf("vec%0d", i), w, u, r);
      check($sformatf("vec%0d period", i), 64'(cyc - prev_fs), 64'(PERIOD));
      prev_fs = cyc;
      check($sformatf("vec%0d underrun", i), 64'(u), 64'(vt[i].exp_ur));
      check($sformatf("vec%0d ready at fs", i), 64'(r), 64'd1);
      capture(sdw, wsw);
      check_frame($sformatf("vec%0d", i), sdw, wsw, vt[i].exp_l, vt[i].exp_r);
    end

    // Producer keeps offering; exactly one pair per frame must get through.
    fork
      begin
        for (int k = 1; k <= 5; k++) offer(16'(k), 16'(16'h1000 + k));
      end
      begin
        int fw;
        logic fu, fr;
        logic [63:0] fsd, fws;
        for (int f = 1; f <= 4; f++) begin
          wait_fs($sformatf("stream%0d", f), fw, fu, fr);
          check($sformatf("stream%0d period", f), 64'(cyc - prev_fs), 64'(PERIOD));
          prev_fs = cyc;
          check($sformatf("stream%0d underrun", f), 64'(fu), 64'd0);
          capture(fsd, fws);
          check($sformatf("stream%0d left", f), 64'(fsd[63:48]), 64'(f));
          check($sformatf("stream%0d right", f), 64'(fsd[31:16]), 64'(16'h1000 + f));
        end
      end
    join

    // Frame 5 carries the last streamed pair; a new pair waits in the buffer
    // while the frame is aborted at bit 20.
    wait_fs("stream5", w, u, r);
    check("stream5 underrun", 64'(u), 64'd0);
    offer(16'h5A5A, 16'h00FF);
    count_falls(20);
    repeat (4) tick();
    check("pre-disable sck high", 64'(sck), 64'd1);
    enable = 1'b0;
    tick();
    check("disable outputs", 64'({sck, ws, sd}), 64'd0);
    moved = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (sck || fs || ws || sd) moved = 1'b1;
    end
    check("idle stays quiet", 64'(moved), 64'd0);
    check("idle keeps buffer", 64'(snd.sample_ready), 64'd0);
    enable = 1'b1;
    wait_fs("re-enable", w, u, r);
    check("re-enable fs latency", 64'(w), 64'd8);
    check("re-enable underrun", 64'(u), 64'd0);
    prev_fs = cyc;
    capture(sdw, wsw);
    check_frame("re-enable frame", sdw, wsw, 16'h5A5A, 16'h00FF);

    // Asynchronous reset in the right slot at bit 40 with SCK, WS and SD high.
    wait_fs("repeat", w, u, r);
    check("repeat period", 64'(cyc - prev_fs), 64'(PERIOD));
    check("repeat underrun", 64'(u), 64'd1);
    offer(16'hDEAD, 16'hBEEF);
    count_falls(40);
    repeat (4) tick();
    check("pre-reset sck/ws/sd", 64'({sck, ws, sd}), 64'b111);
    check("pre-reset ready", 64'(snd.sample_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("async reset outputs", 64'({sck, ws, sd, fs, ur}), 64'd0);
    check("async reset ready", 64'(snd.sample_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    wait_fs("post-reset", w, u, r);
    check("post-reset fs latency", 64'(w), 64'd8);
    check("post-reset underrun", 64'(u), 64'd1);
    capture(sdw, wsw);
    check_frame("post-reset frame", sdw, wsw, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
